// File: rtl/maniac_pkg.sv
// Shared definitions for the maniac GPIO block: register map and debounce counter sizing.
package maniac_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_IN     = 3'd0;
  localparam reg_addr_t ADDR_OUT_LO = 3'd1;
  localparam reg_addr_t ADDR_OUT_HI = 3'd2;
  localparam reg_addr_t ADDR_EDGE   = 3'd3;
  localparam reg_addr_t ADDR_IE     = 3'd4;

  // Counter must hold values up to cycles-1.
  function automatic int deb_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/maniac_debounce.sv
// One switch channel: 2-flop synchroniser followed by a stability counter.
// rise pulses in the cycle whose clock edge moves the debounced value 0->1.
module maniac_debounce
  import maniac_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_32,
  input  logic rst_n,
  input  logic sw_in,
  output logic deb,
  output logic rise
);
  localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             deb_reg, deb_next;

  always_comb begin
    cnt_next = cnt_reg;
    deb_next = deb_reg;
    if (sync_reg[1] == deb_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      deb_next = sync_reg[1];
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_32) begin
    if (!rst_n) begin
      sync_reg <= '0;
      cnt_reg  <= '0;
      deb_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], sw_in};
      cnt_reg  <= cnt_next;
      deb_reg  <= deb_next;
    end
  end

  assign deb  = deb_reg;
  assign rise = deb_next & ~deb_reg;

endmodule

// File: rtl/maniac_gpio.sv
// GPIO block: debounced switch inputs with rising-edge status and level IRQ,
// plus a byte-addressed register file driving a parallel output port.
module maniac_gpio
  import maniac_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 12,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk_32,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  sw_in,
  input  logic [2:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic [OUT_W-1:0] port_out,
  output logic             irq
);
  logic [IN_W-1:0]  deb_vec, rise_vec;
  logic [IN_W-1:0]  edge_reg, edge_next, edge_clr;
  logic [IN_W-1:0]  ie_reg, ie_next;
  logic [OUT_W-1:0] port_reg, port_next;
  logic [15:0]      port_cur;
  logic [7:0]       rdata_reg, rd_mux;
  logic             rvalid_reg, irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_chan
      maniac_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk_32 (clk_32),
        .rst_n  (rst_n),
        .sw_in  (sw_in[gi]),
        .deb    (deb_vec[gi]),
        .rise   (rise_vec[gi])
      );
    end

    // Each port bit belongs to the low or high byte register.
    for (gi = 0; gi < OUT_W; gi++) begin : g_port
      localparam reg_addr_t BYTE_ADDR = (gi < 8) ? ADDR_OUT_LO : ADDR_OUT_HI;
      assign port_next[gi] = (we && addr == BYTE_ADDR) ? wdata[gi % 8] : port_reg[gi];
    end
  endgenerate

  assign port_cur = 16'(port_reg);
  assign edge_clr = (we && addr == ADDR_EDGE) ? wdata[IN_W-1:0] : '0;
  // Set is applied after clear so a simultaneous rising edge survives the W1C.
  assign edge_next = (edge_reg & ~edge_clr) | rise_vec;
  assign ie_next   = (we && addr == ADDR_IE) ? wdata[IN_W-1:0] : ie_reg;

  // Reads see pre-write state, so a combined read/write returns the old value.
  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_IN:     rd_mux = 8'(deb_vec);
      ADDR_OUT_LO: rd_mux = port_cur[7:0];
      ADDR_OUT_HI: rd_mux = port_cur[15:8];
      ADDR_EDGE:   rd_mux = 8'(edge_reg);
      ADDR_IE:     rd_mux = 8'(ie_reg);
      default:     rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_32) begin
    if (!rst_n) begin
      edge_reg   <= '0;
      ie_reg     <= '0;
      port_reg   <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      edge_reg   <= edge_next;
      ie_reg     <= ie_next;
      port_reg   <= port_next;
      rvalid_reg <= re;
      irq_reg    <= |(edge_reg & ie_reg);
      if (re) begin
        rdata_reg <= rd_mux;
      end
    end
  end

  assign rdata    = rdata_reg;
  assign rvalid   = rvalid_reg;
  assign port_out = port_reg;
  assign irq      = irq_reg;

endmodule
